keypad_scan_ctrl: RTL

Scan controller for the 4x4 matrix keypad. It drives the column lines one at a time, samples the row lines through a synchronizer and debounces presses. It emits a 4-bit {col,row} key code with a one-cycle valid strobe. The key code feeds the keypad code-to-hex encoder, whose output drives the 7-segment decoder.

---
 rtl/keypad_pkg.sv | 35 +++
 rtl/sync_2ff.sv | 32 +++
 rtl/keypad_scan_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scan controller.
//   scan_state_t  : scan FSM states
//   SETTLE_CYCLES : cycles after a column switch before rows are trusted
//   COL_RESET     : column drive after reset (column 0 low)
//   ROWS_IDLE     : synchronized row value with no key active
//   row_prio()    : index of the lowest active-low bit in a 4-bit pattern
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } scan_state_t;

  localparam int unsigned SETTLE_CYCLES = 3;
  localparam logic [3:0]  COL_RESET     = 4'b1110;
  localparam logic [3:0]  ROWS_IDLE     = 4'hF;

  // Lowest index wins when several bits are low; all-high returns 3.
  function automatic logic [1:0] row_prio(input logic [3:0] pat);
    logic [1:0] idx;
    if (!pat[0]) begin
      idx = 2'd0;
    end else if (!pat[1]) begin
      idx = 2'd1;
    end else if (!pat[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
// Ports:
//   clk  : destination clock
//   rst  : synchronous active-high reset, loads RESET_VAL into both stages
//   d    : asynchronous input
//   q    : synchronized output, two cycles behind d
module sync_2ff #(
  parameter int unsigned           WIDTH     = 4,
  parameter logic [WIDTH-1:0]      RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Scan controller for a 4x4 matrix keypad. Drives one column low at a time,
// synchronizes and debounces the rows, and reports the accepted key.
// Ports:
//   clk       : system clock
//   rst       : synchronous active-high reset
//   row_n     : keypad rows, asynchronous, active-low
//   col_n     : column drive, active-low, exactly one bit low
//   key_code  : {col[1:0], row[1:0]} of the last accepted key
//   key_valid : one-cycle strobe marking a new (or repeated) key
//   key_held  : high from acceptance until the release is debounced
// Optional feature macro: KEYPAD_AUTOREPEAT_EN (auto-repeat of key_valid
// every REPEAT_CYCLES while the key stays pressed).
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = 5000,
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned REPEAT_CYCLES   = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  if (SCAN_DIV < 8) begin : g_bad_scan_div
    $error("SCAN_DIV must be at least 8");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if (REPEAT_CYCLES < 2) begin : g_bad_repeat
    $error("REPEAT_CYCLES must be at least 2");
  end

  localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
  localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES);

  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [SCAN_W-1:0] SETTLE    = SCAN_W'(SETTLE_CYCLES);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0] row_s;

  sync_2ff #(
    .WIDTH     (4),
    .RESET_VAL (ROWS_IDLE)
  ) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d   (row_n),
    .q   (row_s)
  );

  scan_state_t       state_q, state_d;
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic [3:0]        col_n_q, col_n_d;
  logic [1:0]        col_idx_q, col_idx_d;
  logic [3:0]        row_pat_q, row_pat_d;
  logic [3:0]        key_code_q, key_code_d;
  logic              key_valid_q, key_valid_d;
  logic              key_held_q, key_held_d;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned       REP_W    = $clog2(REPEAT_CYCLES);
  localparam logic [REP_W-1:0]  REP_LAST = REP_W'(REPEAT_CYCLES - 1);
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
`endif

  always_comb begin
    state_d     = state_q;
    scan_cnt_d  = scan_cnt_q;
    deb_cnt_d   = deb_cnt_q;
    col_n_d     = col_n_q;
    col_idx_d   = col_idx_q;
    row_pat_d   = row_pat_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_cnt_d   = rep_cnt_q;
`endif

    unique case (state_q)
      SCAN: begin
        // A detected press wins over the column rotation; the column freezes.
        if ((scan_cnt_q >= SETTLE) && (row_s != ROWS_IDLE)) begin
          state_d   = DEBOUNCE;
          col_idx_d = row_prio(col_n_q);
          row_pat_d = row_s;
          deb_cnt_d = '0;
        end else if (scan_cnt_q == SCAN_LAST) begin
          scan_cnt_d = '0;
          col_n_d    = {col_n_q[2:0], col_n_q[3]};
        end else begin
          scan_cnt_d = scan_cnt_q + 1'b1;
        end
      end

      DEBOUNCE: begin
        if (row_s == row_pat_q) begin
          if (deb_cnt_q == DEB_LAST) begin
            state_d     = PRESSED;
            deb_cnt_d   = '0;
            key_code_d  = {col_idx_q, row_prio(row_pat_q)};
            key_valid_d = 1'b1;
            key_held_d  = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt_d   = '0;
`endif
          end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
          end
        end else begin
          // Bounce: retry the same column from the start of its slot.
          state_d    = SCAN;
          scan_cnt_d = '0;
        end
      end

      PRESSED: begin
`ifdef KEYPAD_AUTOREPEAT_EN
        if (rep_cnt_q == REP_LAST) begin
          rep_cnt_d   = '0;
          key_valid_d = 1'b1;
        end else begin
          rep_cnt_d = rep_cnt_q + 1'b1;
        end
`endif
        // Other rows going active here (a second key) are deliberately ignored.
        if (row_s == ROWS_IDLE) begin
          state_d   = RELEASE;
          deb_cnt_d = '0;
        end
      end

      RELEASE: begin
        if (row_s == ROWS_IDLE) begin
          if (deb_cnt_q == DEB_LAST) begin
            state_d    = SCAN;
            key_held_d = 1'b0;
            scan_cnt_d = '0;
            col_n_d    = {col_n_q[2:0], col_n_q[3]};
          end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
          end
        end else begin
          state_d = PRESSED;
`ifdef KEYPAD_AUTOREPEAT_EN
          rep_cnt_d = '0;
`endif
        end
      end

      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SCAN;
      scan_cnt_q  <= '0;
      deb_cnt_q   <= '0;
      col_n_q     <= COL_RESET;
      col_idx_q   <= 2'd0;
      row_pat_q   <= ROWS_IDLE;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      scan_cnt_q  <= scan_cnt_d;
      deb_cnt_q   <= deb_cnt_d;
      col_n_q     <= col_n_d;
      col_idx_q   <= col_idx_d;
      row_pat_q   <= row_pat_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt_q   <= rep_cnt_d;
`endif
    end
  end

  assign col_n     = col_n_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule
